// File: rtl/gf_mul_seq.sv
// Iterative GF(2^WIDTH) multiplier: Horner evaluation over the multiplier bits, MSB first,
// BITS_PER_CYCLE bits per clock, with optional XOR-accumulate into the result register.
module gf_mul_seq #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] POLY           = 8'h1B,
  parameter int               BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_chain;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc_step;
  logic             w_accept;
  logic             w_last;

  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] sh;
    sh = {v[WIDTH-2:0], 1'b0};
    if (v[WIDTH-1]) begin
      return sh ^ POLY;
    end else begin
      return sh;
    end
  endfunction

  assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'(N - 1));

  // Horner step: r_b is shifted left each cycle, so its top bits are always the next ones due.
  always_comb begin : p_step
    logic [WIDTH-1:0] v;
    v = r_acc;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (r_b[WIDTH-1-k]) begin
        v = xtime(v) ^ r_a;
      end else begin
        v = xtime(v);
      end
    end
    w_acc_step = v;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_BUSY;
        else          w_state_next = S_IDLE;
      end
      S_BUSY: begin
        if (w_last) w_state_next = S_DONE;
        else        w_state_next = S_BUSY;
      end
      S_DONE: begin
        if (w_accept)       w_state_next = S_BUSY;
        else if (out_ready) w_state_next = S_IDLE;
        else                w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_chain <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= lhs;
      r_b     <= rhs;
      r_chain <= chain;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc <= w_acc_step;
      r_b   <= r_b << BITS_PER_CYCLE;
      r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
    end
  end

  // Result register; o is only written on the final step so chain can accumulate against it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o         <= '0;
      out_valid <= 1'b0;
    end else if ((r_state == S_BUSY) && w_last) begin
      o         <= w_acc_step ^ (r_chain ? o : '0);
      out_valid <= 1'b1;
    end else if ((r_state == S_DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gf_mul_seq.sv
// Self-checking bench for gf_mul_seq: five parameterisations checked against a
// shift-and-add GF(2^m) reference model, plus directed handshake and reset cases.
module tb_gf_mul_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [5];
  logic [7:0] la   [5];
  logic [7:0] ra   [5];
  logic       ca   [5];
  logic       ordy [5];
  logic [7:0] o_a  [5];
  logic       ov_a [5];
  logic       ir_a [5];

  logic [7:0] o0, o1, o2, o3;
  logic [3:0] o4;
  logic       ov0, ov1, ov2, ov3, ov4;
  logic       ir0, ir1, ir2, ir3, ir4;

  int width_of [5] = '{8, 8, 8, 8, 4};
  int bpc_of   [5] = '{1, 2, 4, 8, 1};
  int poly_of  [5] = '{'h1B, 'h1B, 'h1B, 'h1B, 'h3};
  int model_o  [5] = '{0, 0, 0, 0, 0};
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .lhs(la[0]), .rhs(ra[0]),
    .chain(ca[0]), .out_valid(ov0), .out_ready(ordy[0]), .o(o0));
  gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .BITS_PER_CYCLE(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .lhs(la[1]), .rhs(ra[1]),
    .chain(ca[1]), .out_valid(ov1), .out_ready(ordy[1]), .o(o1));
  gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .BITS_PER_CYCLE(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .lhs(la[2]), .rhs(ra[2]),
    .chain(ca[2]), .out_valid(ov2), .out_ready(ordy[2]), .o(o2));
  gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .BITS_PER_CYCLE(8)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir3), .lhs(la[3]), .rhs(ra[3]),
    .chain(ca[3]), .out_valid(ov3), .out_ready(ordy[3]), .o(o3));
  gf_mul_seq #(.WIDTH(4), .POLY(4'h3), .BITS_PER_CYCLE(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir4), .lhs(la[4][3:0]), .rhs(ra[4][3:0]),
    .chain(ca[4]), .out_valid(ov4), .out_ready(ordy[4]), .o(o4));

  always_comb begin
    o_a[0] = o0;  o_a[1] = o1;  o_a[2] = o2;  o_a[3] = o3;  o_a[4] = {4'h0, o4};
    ov_a[0] = ov0; ov_a[1] = ov1; ov_a[2] = ov2; ov_a[3] = ov3; ov_a[4] = ov4;
    ir_a[0] = ir0; ir_a[1] = ir1; ir_a[2] = ir2; ir_a[3] = ir3; ir_a[4] = ir4;
  end

  // Reference: LSB-first shift-and-add with modular reduction of the shifted multiplicand.
  function automatic int gfmul(input int a, input int b, input int w, input int poly);
    int p;
    int x;
    p = 0;
    x = a;
    for (int i = 0; i < w; i++) begin
      if (((b >> i) & 1) == 1) p = p ^ x;
      x = x << 1;
      if ((x & (1 << w)) != 0) x = x ^ ((1 << w) | poly);
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int i, input int a, input int b, input bit ch);
    int mask;
    mask = (1 << width_of[i]) - 1;
    a = a & mask;
    b = b & mask;
    @(negedge clk);
    chk($sformatf("ready_before_accept%0d", i), ir_a[i], 1);
    la[i] = a[7:0];
    ra[i] = b[7:0];
    ca[i] = ch;
    iv[i] = 1'b1;
    model_o[i] = gfmul(a, b, width_of[i], poly_of[i]) ^ (ch ? model_o[i] : 0);
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
    chk($sformatf("ready_busy%0d", i), ir_a[i], 0);
  endtask

  task automatic collect(input int i);
    int  lat;
    bit  got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (ov_a[i]) got = 1'b1;
    end
    chk($sformatf("latency%0d", i), lat, width_of[i] / bpc_of[i]);
    chk($sformatf("result%0d", i), o_a[i], model_o[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iv[i] = 1'b0; la[i] = 8'h00; ra[i] = 8'h00; ca[i] = 1'b0; ordy[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_o%0d", i), o_a[i], 0);
      chk($sformatf("rst_valid%0d", i), ov_a[i], 0);
      chk($sformatf("rst_ready%0d", i), ir_a[i], 1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(0, 'h57, 'h83, 1'b0); collect(0); chk("c1_const", o_a[0], 'hC1);
    issue(0, 'h87, 'h02, 1'b0); collect(0); chk("reduce_const", o_a[0], 'h15);
    issue(0, 'h57, 'h01, 1'b0); collect(0); chk("ident_const", o_a[0], 'h57);
    issue(0, 'h57, 'h00, 1'b0); collect(0); chk("zero_const", o_a[0], 'h00);

    issue(0, 'h02, 'hD4, 1'b0); collect(0);
    issue(0, 'h03, 'hBF, 1'b1); collect(0);
    issue(0, 'h01, 'h5D, 1'b1); collect(0);
    issue(0, 'h01, 'h30, 1'b1); collect(0); chk("mixcol_const", o_a[0], 'h04);

    for (int i = 1; i < 4; i++) begin
      issue(i, 'h57, 'h83, 1'b0); collect(i); chk($sformatf("sweep_c1_%0d", i), o_a[i], 'hC1);
    end
    issue(4, 'hB, 'h7, 1'b0); collect(4);

    // Backpressure, then accept on the same edge the held result is taken.
    ordy[0] = 1'b0;
    issue(0, 'hC3, 'h9E, 1'b0); collect(0);
    held = o_a[0];
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", ov_a[0], 1);
      chk("bp_o", o_a[0], held);
      chk("bp_ready", ir_a[0], 0);
    end
    @(negedge clk);
    ordy[0] = 1'b1;
    la[0] = 8'h3A; ra[0] = 8'hF1; ca[0] = 1'b1; iv[0] = 1'b1;
    model_o[0] = gfmul('h3A, 'hF1, 8, 'h1B) ^ model_o[0];
    #1;
    chk("bp_ready_comb", ir_a[0], 1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("b2b_valid_drop", ov_a[0], 0);
    chk("b2b_busy_ready", ir_a[0], 0);
    collect(0);

    // Reset mid-operation at step 3.
    issue(0, 'hA5, 'h3C, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_o", o_a[0], 0);
    chk("midrst_valid", ov_a[0], 0);
    chk("midrst_ready", ir_a[0], 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) model_o[i] = 0;
    repeat (12) begin
      @(posedge clk); #1;
      chk("no_stale", ov_a[0], 0);
    end
    issue(0, 'h57, 'h13, 1'b0); collect(0); chk("fe_const", o_a[0], 'hFE);

    for (int r = 0; r < 40; r++) begin
      int i;
      i = $urandom_range(4, 0);
      issue(i, $urandom, $urandom, 1'($urandom_range(1, 0)));
      collect(i);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
